// File: rtl/reg_file_wb_p.sv
// Write-back register file: two registered read ports with write bypass, a pending-write
// scoreboard and a one-entry-per-cycle clear sweep. Optional macro: REG_FILE_R0_ZERO_EN.
module reg_file_wb_p #(
   parameter int DATA_W = 16,
   parameter int N_REGS = 8,
   parameter int ADDR_W = 3
) (
   input  logic              CLK_WB,
   input  logic              RESET_N,
   input  logic              WR_EN,
   input  logic [ADDR_W-1:0] WR_ADDR,
   input  logic [DATA_W-1:0] WR_DATA,
   input  logic              RD0_EN,
   input  logic [ADDR_W-1:0] RD0_ADDR,
   output logic [DATA_W-1:0] RD0_DATA,
   output logic              BUSY0,
   input  logic              RD1_EN,
   input  logic [ADDR_W-1:0] RD1_ADDR,
   output logic [DATA_W-1:0] RD1_DATA,
   output logic              BUSY1,
   input  logic              LOCK_EN,
   input  logic [ADDR_W-1:0] LOCK_ADDR,
   input  logic              CLEAR_REQ,
   output logic              CLEAR_BUSY
);

   localparam logic [0:0]        IDLE  = 1'b0;
   localparam logic [0:0]        SWEEP = 1'b1;
   localparam logic [ADDR_W:0]   N_EXT = (ADDR_W + 1)'(N_REGS);
   localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(N_REGS - 1);
`ifdef REG_FILE_R0_ZERO_EN
   localparam logic R0_ZERO = 1'b1;
`else
   localparam logic R0_ZERO = 1'b0;
`endif

   function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
      return ({1'b0, a} < N_EXT);
   endfunction

   // Targets that may be written or locked; a hardwired-zero r0 is excluded.
   function automatic logic target_ok(input logic [ADDR_W-1:0] a);
      return addr_ok(a) && !(R0_ZERO && (a == '0));
   endfunction

   logic [DATA_W-1:0] mem_r [N_REGS];
   logic [N_REGS-1:0] busy_r;
   logic [0:0]        state_r;
   logic [ADDR_W-1:0] cnt_r;
   logic [DATA_W-1:0] rd0_r;
   logic [DATA_W-1:0] rd1_r;
   logic [DATA_W-1:0] rd0_nxt_s;
   logic [DATA_W-1:0] rd1_nxt_s;
   logic              idle_s;
   logic              wr_act_s;
   logic              lock_act_s;

   // Qualified write/lock strobes and hazard flags for the read ports.
   always_comb begin
      idle_s     = (state_r == IDLE);
      wr_act_s   = WR_EN && idle_s && target_ok(WR_ADDR);
      lock_act_s = LOCK_EN && idle_s && target_ok(LOCK_ADDR);
      BUSY0 = addr_ok(RD0_ADDR) && busy_r[RD0_ADDR]
              && !(WR_EN && idle_s && (WR_ADDR == RD0_ADDR));
      BUSY1 = addr_ok(RD1_ADDR) && busy_r[RD1_ADDR]
              && !(WR_EN && idle_s && (WR_ADDR == RD1_ADDR));
   end

   // Next read data: hold when disabled, forward a same-cycle write, else array.
   always_comb begin
      rd0_nxt_s = rd0_r;
      rd1_nxt_s = rd1_r;
      if (!RD0_EN) begin
         rd0_nxt_s = rd0_r;
      end else if (wr_act_s && (WR_ADDR == RD0_ADDR)) begin
         rd0_nxt_s = WR_DATA;
      end else if (addr_ok(RD0_ADDR)) begin
         rd0_nxt_s = mem_r[RD0_ADDR];
      end else begin
         rd0_nxt_s = '0;
      end
      if (!RD1_EN) begin
         rd1_nxt_s = rd1_r;
      end else if (wr_act_s && (WR_ADDR == RD1_ADDR)) begin
         rd1_nxt_s = WR_DATA;
      end else if (addr_ok(RD1_ADDR)) begin
         rd1_nxt_s = mem_r[RD1_ADDR];
      end else begin
         rd1_nxt_s = '0;
      end
   end

   // Storage array: sweep clears take priority and block the write port.
   always_ff @(posedge CLK_WB or negedge RESET_N) begin
      if (!RESET_N) begin
         for (int i = 0; i < N_REGS; i++) mem_r[i] <= '0;
      end else if (state_r == SWEEP) begin
         mem_r[cnt_r] <= '0;
      end else if (wr_act_s) begin
         mem_r[WR_ADDR] <= WR_DATA;
      end
   end

   // Scoreboard: a lock issued in the same cycle as the write-back wins.
   always_ff @(posedge CLK_WB or negedge RESET_N) begin
      if (!RESET_N) begin
         busy_r <= '0;
      end else if (state_r == SWEEP) begin
         busy_r[cnt_r] <= 1'b0;
      end else begin
         if (wr_act_s)   busy_r[WR_ADDR]   <= 1'b0;
         if (lock_act_s) busy_r[LOCK_ADDR] <= 1'b1;
      end
   end

   // Clear sequencer; requests during a sweep are ignored.
   always_ff @(posedge CLK_WB or negedge RESET_N) begin
      if (!RESET_N) begin
         state_r <= IDLE;
         cnt_r   <= '0;
      end else begin
         case (state_r)
            IDLE: begin
               if (CLEAR_REQ) begin
                  state_r <= SWEEP;
                  cnt_r   <= '0;
               end
            end
            SWEEP: begin
               if (cnt_r == LAST) begin
                  state_r <= IDLE;
                  cnt_r   <= '0;
               end else begin
                  cnt_r <= cnt_r + ADDR_W'(1);
               end
            end
            default: begin
               state_r <= IDLE;
               cnt_r   <= '0;
            end
         endcase
      end
   end

   // Registered read ports.
   always_ff @(posedge CLK_WB or negedge RESET_N) begin
      if (!RESET_N) begin
         rd0_r <= '0;
         rd1_r <= '0;
      end else begin
         rd0_r <= rd0_nxt_s;
         rd1_r <= rd1_nxt_s;
      end
   end

   assign RD0_DATA   = rd0_r;
   assign RD1_DATA   = rd1_r;
   assign CLEAR_BUSY = (state_r == SWEEP);

endmodule

// File: doc/reg_file_wb_p.md
Name: reg_file_wb_p

Overview:
- Parametrised write-back register file for the next cpu15 generation: N_REGS x DATA_W storage, one write-back port, two registered read ports.
- Write-to-read bypass on both read ports.
- Per-register scoreboard (pending-write busy bits) for hazard detection.
- Sequenced clear engine that zeroes the file one entry per cycle without a reset.
- Sits between the write-back stage (write side) and decode/operand fetch (read side).

Parameters:
DATA_W, 16, register width in bits
N_REGS, 8, number of registers (2..256)
ADDR_W, 3, address width; 2**ADDR_W >= N_REGS is required

Ports:
CLK_WB  in  1  clock; all state changes on rising edge
RESET_N  in  1  asynchronous, active-low reset
WR_EN  in  1  write-back enable
WR_ADDR  in  ADDR_W  write-back register number
WR_DATA  in  DATA_W  write-back data
RD0_EN  in  1  read port 0 enable
RD0_ADDR  in  ADDR_W  read port 0 register number
RD0_DATA  out  DATA_W  read port 0 data, registered
BUSY0  out  1  scoreboard bit for RD0_ADDR, combinational
RD1_EN, RD1_ADDR, RD1_DATA, BUSY1: identical to port 0
LOCK_EN  in  1  mark LOCK_ADDR as pending write (instruction issue)
LOCK_ADDR  in  ADDR_W  register to mark busy
CLEAR_REQ  in  1  start clear sweep (single-cycle pulse sufficient)
CLEAR_BUSY  out  1  high while sweep in progress

Behaviour:
- Reset (RESET_N low, async):
  - All registers = 0; all busy bits = 0.
  - RD0_DATA = RD1_DATA = 0.
  - FSM = IDLE, sweep counter = 0, CLEAR_BUSY = 0.
- Write, FSM IDLE:
  - WR_EN=1 with WR_ADDR < N_REGS: reg[WR_ADDR] <= WR_DATA at the edge.
  - WR_ADDR >= N_REGS: write ignored.
- Read, latency 1:
  - RDx_EN=1 at edge k: RDx_DATA valid after edge k.
  - RDx_EN=0: RDx_DATA holds its previous value.
  - Address >= N_REGS reads 0.
- Bypass: RDx_EN=1, WR_EN=1, FSM IDLE and RDx_ADDR==WR_ADDR in the same cycle: RDx_DATA <= WR_DATA (new value, not old).
- Scoreboard:
  - LOCK_EN sets busy[LOCK_ADDR]; WR_EN in IDLE clears busy[WR_ADDR].
  - Same address, same cycle: set wins (a newer writer has been issued).
  - BUSYx = busy[RDx_ADDR] AND NOT (WR_EN AND IDLE AND WR_ADDR==RDx_ADDR). A same-cycle write-back resolves the hazard via bypass.
  - Address >= N_REGS: BUSYx = 0; LOCK ignored.
- Clear FSM, states IDLE, SWEEP:
  - IDLE -> SWEEP on CLEAR_REQ=1; counter = 0.
  - In SWEEP, each cycle: reg[cnt] <= 0, busy[cnt] <= 0, cnt++.
  - After cnt == N_REGS-1 is cleared: -> IDLE. Sweep lasts exactly N_REGS cycles.
  - CLEAR_BUSY = 1 exactly in SWEEP.
  - In SWEEP, WR_EN and LOCK_EN are ignored (dropped; upstream must stall on CLEAR_BUSY).
  - Reads in SWEEP return current array contents; no bypass.
  - CLEAR_REQ while in SWEEP is ignored (no restart).
  - RESET_N low mid-sweep: immediate reset, FSM IDLE.

Optional Feature:
REG_FILE_R0_ZERO_EN:
- Defined: register 0 is hardwired zero. Writes to address 0 are discarded. Reads and bypass of address 0 return 0. busy[0] is never set, so BUSYx = 0 for address 0. The sweep still takes N_REGS cycles.
- Undefined: register 0 is an ordinary register.

Test Plan:
- Reset, then WR_EN addr 3 data 16'hA5A5, next cycle RD0_EN addr 3 -> RD0_DATA = 16'hA5A5 one edge later; RD1 addr 4 -> 16'h0000.
- Same cycle: WR_EN addr 5 data 16'h1234 and RD0_EN/RD1_EN both addr 5 -> both RDx_DATA = 16'h1234 after that edge; BUSY0 = 0 that cycle.
- LOCK_EN addr 2 -> BUSY0 (addr 2) = 1 next cycle. Then LOCK_EN addr 2 + WR_EN addr 2 together -> busy stays 1. Then WR_EN addr 2 alone -> BUSY0 = 0.
- Fill all 8 regs with 16'hFFFF and lock regs 1,6; pulse CLEAR_REQ -> CLEAR_BUSY high exactly 8 cycles. WR_EN addr 0 data 16'h0042 mid-sweep is dropped. Afterwards all regs read 0 and all BUSY = 0.
- Mid-sweep (cycle 4) assert RESET_N = 0 asynchronously -> CLEAR_BUSY, RD0_DATA, RD1_DATA drop to 0 without a clock edge; after release, FSM IDLE and a write/read to addr 7 works.
- With REG_FILE_R0_ZERO_EN: WR_EN addr 0 data 16'hBEEF plus RD0_EN addr 0 same cycle -> RD0_DATA = 0; LOCK_EN addr 0 -> BUSY0 = 0.
